// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-to-decode handshake, imem port and redirect bundle.
// FETCH_BUBBLE_COUNT_EN adds bubble_count_fd.
interface fetch_stage_if;
    logic        stall_fd;
    logic        redirect;
    logic [11:0] redirect_addr;
    logic [11:0] address_imem;
    logic [31:0] q_imem;
    logic [31:0] q_imem_fd;
    logic [11:0] next_iaddr_fd;
    logic        valid_fd;
`ifdef FETCH_BUBBLE_COUNT_EN
    logic [15:0] bubble_count_fd;
    modport master(input stall_fd, redirect, redirect_addr, q_imem,
                   output address_imem, q_imem_fd, next_iaddr_fd, valid_fd, bubble_count_fd);
    modport slave(output stall_fd, redirect, redirect_addr, q_imem,
                  input address_imem, q_imem_fd, next_iaddr_fd, valid_fd, bubble_count_fd);
`else
    modport master(input stall_fd, redirect, redirect_addr, q_imem,
                   output address_imem, q_imem_fd, next_iaddr_fd, valid_fd);
    modport slave(output stall_fd, redirect, redirect_addr, q_imem,
                  input address_imem, q_imem_fd, next_iaddr_fd, valid_fd);
`endif
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: 12-bit PC, synchronous imem fetch and F/D latch with stall skid and redirect squash.
// FETCH_BUBBLE_COUNT_EN adds a saturating count of bubbles loaded into F/D.
module fetch_stage (
    input logic clock,
    input logic reset,
    fetch_stage_if.master fif
);
    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HELD = 1'b1;
    logic [11:0] pc, req_pc, next_iaddr;
    logic        req_valid, valid;
    logic [0:0]  state;
    logic [31:0] skid_q, q_fd;
    assign fif.address_imem  = fif.redirect ? fif.redirect_addr : pc;
    assign fif.q_imem_fd     = q_fd;
    assign fif.next_iaddr_fd = next_iaddr;
    assign fif.valid_fd      = valid;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc         <= '0;
            req_pc     <= '0;
            req_valid  <= 1'b0;
            state      <= RUN;
            skid_q     <= '0;
            q_fd       <= '0;
            next_iaddr <= '0;
            valid      <= 1'b0;
        end else if (fif.redirect) begin
            pc         <= fif.redirect_addr + 12'd1;
            req_pc     <= fif.redirect_addr;
            req_valid  <= 1'b1;
            state      <= RUN;
            q_fd       <= '0;
            next_iaddr <= '0;
            valid      <= 1'b0;
        end else if (fif.stall_fd) begin
            // Capture the in-flight word once; imem output moves on after this edge.
            if (state == RUN && req_valid) begin
                skid_q <= fif.q_imem;
                state  <= HELD;
            end
        end else begin
            q_fd       <= state == HELD ? skid_q : (req_valid ? fif.q_imem : '0);
            next_iaddr <= req_pc + 12'd1;
            valid      <= state == HELD || req_valid;
            req_pc     <= pc;
            req_valid  <= 1'b1;
            pc         <= pc + 12'd1;
            state      <= RUN;
        end
    end
`ifdef FETCH_BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
    logic        load_bubble;
    assign load_bubble = fif.redirect || (!fif.stall_fd && state == RUN && !req_valid);
    assign fif.bubble_count_fd = bubble_count;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) bubble_count <= '0;
        else if (load_bubble && bubble_count != 16'hFFFF) bubble_count <= bubble_count + 16'd1;
    end
`endif
endmodule
